// File: rtl/lc3_regfile_cc_if.sv
// Bus-side signal bundle between the LC-3 control/datapath and the GPR/NZP receiver.
// master: control FSM / datapath side, slave: lc3_regfile_cc.
interface lc3_regfile_cc_if #(
  parameter int W = 16
);
  logic [W-1:0] bus;
  logic         ld_reg;
  logic [2:0]   dr;
  logic         ld_cc;
  logic [2:0]   sr1;
  logic [2:0]   sr2;
  logic [W-1:0] sr1_out;
  logic [W-1:0] sr2_out;
  logic [2:0]   nzp;
  logic         bus_err;

  modport master (
    output bus, ld_reg, dr, ld_cc, sr1, sr2,
    input  sr1_out, sr2_out, nzp, bus_err
  );

  modport slave (
    input  bus, ld_reg, dr, ld_cc, sr1, sr2,
    output sr1_out, sr2_out, nzp, bus_err
  );
endinterface

// File: rtl/lc3_regfile_cc.sv
// LC-3 general-purpose register file and NZP condition codes.
// Captures the shared bus into GPR[dr] on ld_reg and updates NZP on ld_cc;
// two combinational read ports feed the ALU operands.
// Optional feature macro: LC3_REGFILE_BYPASS_EN (write-through forward of bus
// onto a read port whose index matches dr while ld_reg is high).
module lc3_regfile_cc #(
  parameter int         NREG   = 8,
  parameter int         W      = 16,
  parameter logic [2:0] CC_RST = 3'b010
) (
  input logic             clk,
  input logic             rst_n,
  lc3_regfile_cc_if.slave rf
);

  localparam int         AW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [3:0] NREG_L = 4'(NREG);

  typedef enum logic [2:0] {
    CC_P = 3'b001,
    CC_Z = 3'b010,
    CC_N = 3'b100
  } cc_e;

  logic [W-1:0] gpr_q [NREG];
  logic [W-1:0] gpr_d [NREG];
  cc_e          cc_q, cc_d;
  logic         bus_err_q, bus_err_d;
  logic         bus_x;
  logic         dr_ok;

  assign dr_ok = ({1'b0, rf.dr} < NREG_L);

  // Unknown-bus detection only has meaning in a 4-state simulator.
`ifndef SYNTHESIS
  assign bus_x = (rf.ld_reg | rf.ld_cc) && ((^rf.bus) === 1'bx);
`else
  assign bus_x = 1'b0;
`endif

  // Next-state for GPRs: out-of-range dr silently discards the write.
  always_comb begin
    gpr_d = gpr_q;
    if (rf.ld_reg && dr_ok) begin
      gpr_d[rf.dr[AW-1:0]] = rf.bus;
    end
  end

  // Next-state for NZP: exactly one code bit set, derived from the bus value.
  always_comb begin
    cc_d = cc_q;
    if (rf.ld_cc) begin
      if (rf.bus[W-1]) begin
        cc_d = CC_N;
      end else if (rf.bus == '0) begin
        cc_d = CC_Z;
      end else begin
        cc_d = CC_P;
      end
    end
  end

  // Sticky bus error flag, cleared only by reset.
  always_comb begin
    bus_err_d = bus_err_q | bus_x;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_q     <= '{default: '0};
      cc_q      <= cc_e'(CC_RST);
      bus_err_q <= 1'b0;
    end else begin
      gpr_q     <= gpr_d;
      cc_q      <= cc_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Read port mux: stored value, or the bus when forwarding is enabled.
  function automatic logic [W-1:0] rd_port(input logic [2:0] sel);
    logic [W-1:0] v;
    v = '0;
    if ({1'b0, sel} < NREG_L) begin
      v = gpr_q[sel[AW-1:0]];
    end
`ifdef LC3_REGFILE_BYPASS_EN
    if (rf.ld_reg && dr_ok && (rf.dr == sel)) begin
      v = rf.bus;
    end
`endif
    return v;
  endfunction

  // Combinational read ports and registered status outputs.
  always_comb begin
    rf.sr1_out = rd_port(rf.sr1);
    rf.sr2_out = rd_port(rf.sr2);
    rf.nzp     = cc_q;
    rf.bus_err = bus_err_q;
  end

endmodule

// File: tb/tb_lc3_regfile_cc.sv
// Self-checking bench for lc3_regfile_cc: directed scenarios plus a randomized
// run compared against an array/arithmetic reference model.
module tb_lc3_regfile_cc;

  logic clk;
  logic rst_n;

  lc3_regfile_cc_if #(.W(16)) bif ();

  lc3_regfile_cc #(.NREG(8), .W(16), .CC_RST(3'b010)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_reg [8];
  logic [2:0]  m_nzp;
  logic        m_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_nzp = 3'b010;
    m_err = 1'b0;
  endtask

  task automatic idle_inputs();
    bif.bus    = 16'h0000;
    bif.ld_reg = 1'b0;
    bif.ld_cc  = 1'b0;
    bif.dr     = 3'd0;
    bif.sr1    = 3'd0;
    bif.sr2    = 3'd0;
  endtask

  // Advance one rising edge and apply the architectural effect to the model.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if ((bif.ld_reg || bif.ld_cc) && $isunknown(bif.bus)) m_err = 1'b1;
      if (bif.ld_cc) begin
        if ($isunknown(bif.bus))            m_nzp = 3'bxxx;
        else if ($signed(bif.bus) < 0)      m_nzp = 3'b100;
        else if (bif.bus == 16'd0)          m_nzp = 3'b010;
        else                                m_nzp = 3'b001;
      end
      if (bif.ld_reg) m_reg[bif.dr] = bif.bus;
    end
    #1;
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] s);
`ifdef LC3_REGFILE_BYPASS_EN
    if (bif.ld_reg && bif.dr == s) return bif.bus;
`endif
    return m_reg[s];
  endfunction

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    if (bif.nzp !== 3'b010) begin
      errors++; $display("FAIL reset_nzp got=%b exp=010", bif.nzp);
    end
    checks++;
    if (bif.bus_err !== 1'b0) begin
      errors++; $display("FAIL reset_bus_err got=%b exp=0", bif.bus_err);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      bif.sr1 = 3'(i);
      bif.sr2 = 3'(7 - i);
      #1;
      if (bif.sr1_out !== 16'h0000 || bif.sr2_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_gpr i=%0d got=%h/%h exp=0000/0000", i, bif.sr1_out, bif.sr2_out);
      end
      checks++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    idle_inputs();
    bif.bus = 16'h1234; bif.ld_reg = 1'b1; bif.dr = 3'd3;
    tick();
    idle_inputs();
    bif.sr1 = 3'd3; bif.sr2 = 3'd4;
    #1;
    if (bif.sr1_out !== 16'h1234) begin
      errors++; $display("FAIL wr_sr1 got=%h exp=1234", bif.sr1_out);
    end
    checks++;
    if (bif.sr2_out !== 16'h0000) begin
      errors++; $display("FAIL wr_sr2 got=%h exp=0000", bif.sr2_out);
    end
    checks++;
  endtask

  task automatic test_cc();
    logic [15:0] vals [4];
    logic        lds  [4];
    logic [2:0]  exps [4];
    vals = '{16'h8000, 16'h0000, 16'h7FFF, 16'h8000};
    lds  = '{1'b1, 1'b1, 1'b1, 1'b0};
    exps = '{3'b100, 3'b010, 3'b001, 3'b001};
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      bif.bus = vals[i]; bif.ld_cc = lds[i];
      tick();
      if (bif.nzp !== exps[i] || bif.nzp !== m_nzp) begin
        errors++;
        $display("FAIL cc step=%0d bus=%h got=%b exp=%b", i, vals[i], bif.nzp, exps[i]);
      end
      checks++;
    end
  endtask

  task automatic test_raw();
    logic [15:0] pre;
    idle_inputs();
    bif.bus = 16'h1111; bif.ld_reg = 1'b1; bif.dr = 3'd5;
    tick();
    bif.bus = 16'hABCD; bif.ld_reg = 1'b1; bif.dr = 3'd5; bif.sr1 = 3'd5; bif.sr2 = 3'd5;
`ifdef LC3_REGFILE_BYPASS_EN
    pre = 16'hABCD;
`else
    pre = 16'h1111;
`endif
    #1;
    if (bif.sr1_out !== pre || bif.sr2_out !== pre) begin
      errors++; $display("FAIL raw_before got=%h/%h exp=%h", bif.sr1_out, bif.sr2_out, pre);
    end
    checks++;
    tick();
    bif.ld_reg = 1'b0; bif.bus = 16'h0000;
    #1;
    if (bif.sr1_out !== 16'hABCD) begin
      errors++; $display("FAIL raw_after got=%h exp=ABCD", bif.sr1_out);
    end
    checks++;
  endtask

  task automatic test_bus_z();
    idle_inputs();
    bif.bus = 16'hzzzz;
    bif.sr1 = 3'd3; bif.sr2 = 3'd5;
    tick();
    if (bif.bus_err !== m_err || bif.bus_err !== 1'b0) begin
      errors++; $display("FAIL busz_idle_err got=%b exp=0", bif.bus_err);
    end
    checks++;
    if (bif.sr1_out !== m_reg[3] || bif.sr2_out !== m_reg[5] || bif.nzp !== m_nzp) begin
      errors++;
      $display("FAIL busz_idle_state got=%h/%h/%b exp=%h/%h/%b",
               bif.sr1_out, bif.sr2_out, bif.nzp, m_reg[3], m_reg[5], m_nzp);
    end
    checks++;
    bif.ld_cc = 1'b1;
    tick();
    if (bif.bus_err !== m_err) begin
      errors++; $display("FAIL busz_load_err got=%b exp=%b", bif.bus_err, m_err);
    end
    checks++;
    bif.bus = 16'h0001;
    tick();
    bif.ld_cc = 1'b0;
    if (bif.bus_err !== m_err) begin
      errors++; $display("FAIL busz_sticky got=%b exp=%b", bif.bus_err, m_err);
    end
    checks++;
    if (bif.nzp !== 3'b001) begin
      errors++; $display("FAIL busz_cc_recover got=%b exp=001", bif.nzp);
    end
    checks++;
  endtask

  task automatic test_all_regs();
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      bif.bus = 16'(i * 16'h1111); bif.ld_reg = 1'b1; bif.dr = 3'(i);
      tick();
    end
    idle_inputs();
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        bif.sr1 = 3'(a); bif.sr2 = 3'(b);
        #1;
        if (bif.sr1_out !== 16'(a * 16'h1111) || bif.sr2_out !== 16'(b * 16'h1111)) begin
          errors++;
          $display("FAIL allregs a=%0d b=%0d got=%h/%h exp=%h/%h", a, b,
                   bif.sr1_out, bif.sr2_out, 16'(a * 16'h1111), 16'(b * 16'h1111));
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e1, e2;
    for (int n = 0; n < 300; n++) begin
      bif.ld_reg = 1'($urandom_range(0, 1));
      bif.ld_cc  = 1'($urandom_range(0, 1));
      bif.dr     = 3'($urandom_range(0, 7));
      bif.sr1    = 3'($urandom_range(0, 7));
      bif.sr2    = ($urandom_range(0, 3) == 0) ? bif.dr : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       bif.bus = 16'h0000;
        1:       bif.bus = 16'h8000;
        2:       bif.bus = 16'hFFFF;
        default: bif.bus = 16'($urandom);
      endcase
      #1;
      e1 = exp_rd(bif.sr1);
      e2 = exp_rd(bif.sr2);
      if (bif.sr1_out !== e1 || bif.sr2_out !== e2) begin
        errors++;
        $display("FAIL rand_rd n=%0d got=%h/%h exp=%h/%h", n, bif.sr1_out, bif.sr2_out, e1, e2);
      end
      checks++;
      if (bif.nzp !== m_nzp || bif.bus_err !== m_err) begin
        errors++;
        $display("FAIL rand_cc n=%0d got=%b/%b exp=%b/%b", n, bif.nzp, bif.bus_err, m_nzp, m_err);
      end
      checks++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_release();
    #2;
    rst_n = 1'b0;
    model_reset();
    bif.bus = 16'h5555; bif.ld_reg = 1'b1; bif.dr = 3'd2; bif.ld_cc = 1'b1;
    @(posedge clk);
    #1;
    bif.sr1 = 3'd2;
    #1;
    if (bif.sr1_out !== 16'h0000) begin
      errors++; $display("FAIL rst_hold got=%h exp=0000", bif.sr1_out);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle_inputs();
    bif.sr1 = 3'd2;
    #1;
    if (bif.sr1_out !== m_reg[2] || bif.sr1_out !== 16'h5555) begin
      errors++; $display("FAIL rst_release_gpr got=%h exp=5555", bif.sr1_out);
    end
    checks++;
    if (bif.nzp !== 3'b001) begin
      errors++; $display("FAIL rst_release_cc got=%b exp=001", bif.nzp);
    end
    checks++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_cc();
    test_raw();
    test_bus_z();
    test_all_regs();
    test_random();
    test_reset();
    test_reset_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
